// File: rtl/aer_event_fifo.sv
// rtl/aer_event_fifo.sv - single-clock FIFO buffering AER event words to the accelerator core
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   wr_en, din : write request and event word; accepted when not full
//   rd_en      : read request; accepted when not empty
//   dout       : registered read data, valid the cycle after an accepted read
//   full       : FIFO holds DEPTH words
//   empty      : FIFO holds no words
//   data_count : current occupancy, 0..DEPTH
//   overflow   : sticky, set by a write attempted while full
//   underflow  : sticky, set by a read attempted while empty

module aer_event_fifo #(
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

   // Pointers carry one extra wrap bit so equal low bits can mean either
   // empty (wrap bits equal) or full (wrap bits differ).
   logic [ADDR_WIDTH:0]   wptr;
   logic [ADDR_WIDTH:0]   rptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic wr_accept;
   logic rd_accept;

   // Flags and count depend only on the pointer registers, so there is
   // no combinational path from wr_en/rd_en to any status output.
   assign empty      = (wptr == rptr);
   assign full       = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                       (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
   // Modular difference of the extended pointers gives 0..DEPTH directly.
   assign data_count = wptr - rptr;

   assign wr_accept  = wr_en & ~full;
   assign rd_accept  = rd_en & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         dout      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_accept) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_accept) begin
            rptr <= rptr + PTR_ONE;
            dout <= mem[rptr[ADDR_WIDTH-1:0]];
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   // Storage is not reset; a write seen while rst is high only touches a
   // slot that the reset pointers already treat as free.
   always_ff @(posedge clk) begin
      if (wr_accept && !rst) begin
         mem[wptr[ADDR_WIDTH-1:0]] <= din;
      end
   end

endmodule

// File: tb/tb_aer_event_fifo.sv
// tb/tb_aer_event_fifo.sv - scoreboard bench for aer_event_fifo

module tb_aer_event_fifo;

   localparam int DW    = 24;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] din;
   logic          rd_en;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;
   logic [AW:0]   data_count;
   logic          overflow;
   logic          underflow;

   aer_event_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .din        (din),
      .rd_en      (rd_en),
      .dout       (dout),
      .full       (full),
      .empty      (empty),
      .data_count (data_count),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] m_dout;
   logic          m_ovf;
   logic          m_unf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic check_status(input string tag);
      check({tag, "_count"}, 32'(data_count), 32'(sb_q.size()));
      check({tag, "_empty"}, 32'(empty),      32'(sb_q.size() == 0));
      check({tag, "_full"},  32'(full),       32'(sb_q.size() == DEPTH));
      check({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
      check({tag, "_unf"},   32'(underflow),  32'(m_unf));
   endtask

   // One clock cycle: drive inputs, update the scoreboard from pre-edge
   // state, then sample the DUT 1 time unit after the rising edge.
   task automatic cycle(input logic we, input logic [DW-1:0] d, input logic re);
      logic          wa;
      logic          ra;
      logic [DW-1:0] expv;
      wr_en = we;
      din   = d;
      rd_en = re;
      wa    = we && (sb_q.size() < DEPTH);
      ra    = re && (sb_q.size() > 0);
      expv  = '0;
      if (we && !wa) m_ovf = 1'b1;
      if (re && !ra) m_unf = 1'b1;
      if (ra) expv = sb_q.pop_front();
      if (wa) sb_q.push_back(d);
      @(posedge clk);
      #1;
      if (ra) begin
         check("dout", 32'(dout), 32'(expv));
         m_dout = expv;
      end else begin
         check("dout_hold", 32'(dout), 32'(m_dout));
      end
      check_status("cyc");
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      rst   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      model_reset();

      // Reset takes effect before any clock edge.
      #1 rst = 1'b1;
      #1;
      check("rst_dout", 32'(dout), 32'h0);
      check_status("rst");
      @(posedge clk);
      #1 rst = 1'b0;

      // Fill to full, then writes while full are dropped.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(1000 + i), 1'b0);
      check("fill_full", 32'(full), 32'h1);
      check("fill_count", 32'(data_count), 32'd64);
      cycle(1'b1, 24'h000BAD, 1'b0);
      cycle(1'b1, 24'h000BAD, 1'b0);
      check("fill_ovf", 32'(overflow), 32'h1);

      // Drain, then one extra read while empty.
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
      check("drain_empty", 32'(empty), 32'h1);
      cycle(1'b0, '0, 1'b1);
      check("drain_last", 32'(dout), 32'd1063);
      check("drain_unf", 32'(underflow), 32'h1);

      // Write and read together while empty: write only.
      cycle(1'b1, 24'h0000AA, 1'b1);
      cycle(1'b0, '0, 1'b1);
      check("empty_wr_rd", 32'(dout), 32'h0000AA);

      // Overlapping write/read stream.
      for (int i = 0; i < 30; i++) cycle(1'b1, DW'(2000 + i), (i >= 5) && (i < 25));
      check("conc_count", 32'(data_count), 32'd10);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
      check("conc_2022", 32'(dout), 32'd2022);
      while (sb_q.size() > 0) cycle(1'b0, '0, 1'b1);

      // Wrapped pointers: fill, write while full, then read+write while full.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(3000 + i), 1'b0);
      check("wrap_full", 32'(full), 32'h1);
      cycle(1'b1, 24'h000FFF, 1'b0);
      cycle(1'b1, 24'h000FFF, 1'b1);
      check("wrap_rdwr_full", 32'(full), 32'h0);
      while (sb_q.size() > 0) cycle(1'b0, '0, 1'b1);

      // Reset mid-operation with 10 words stored.
      for (int i = 0; i < 10; i++) cycle(1'b1, DW'(4000 + i), 1'b0);
      rst = 1'b1;
      #1;
      model_reset();
      check("mrst_empty", 32'(empty), 32'h1);
      check("mrst_count", 32'(data_count), 32'h0);
      check("mrst_dout", 32'(dout), 32'h0);
      check_status("mrst");
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(1'b1, 24'hABCDEF, 1'b0);
      cycle(1'b0, '0, 1'b1);
      check("mrst_first", 32'(dout), 32'hABCDEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aer_event_fifo.md
Name: aer_event_fifo

Overview:
Single-clock synchronous FIFO buffering 24-bit AER (address-event) words between the AER input receiver and the neural accelerator core. Writes and reads share one clock. Full/empty flags provide flow control; writes when full and reads when empty are dropped and recorded in sticky error flags.

Parameters:
DATA_WIDTH, 24, width of each stored event word
DEPTH, 64, number of storage entries (power of two, >= 4)
ADDR_WIDTH, 6, log2(DEPTH); pointer index width

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
wr_en  input  1  write request; din is captured on a clk edge when wr_en=1 and full=0
din  input  DATA_WIDTH  write data
rd_en  input  1  read request; pops one word on a clk edge when rd_en=1 and empty=0
dout  output  DATA_WIDTH  registered read data
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
data_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately without a clock edge): write pointer=0, read pointer=0, data_count=0, dout=0, empty=1, full=0, overflow=0, underflow=0. Storage contents are don't-care. While rst=1, wr_en and rd_en are ignored.
- Reset asserted mid-operation discards all stored data. The first read after reset release returns the first word written after release.
- Storage: DEPTH x DATA_WIDTH array. Pointers are ADDR_WIDTH+1 bits, and the extra MSB distinguishes full from empty on wrap-around.
- Write accept = wr_en & ~full, evaluated before the edge. On an accepted write: mem[wptr] <= din and wptr increments, wrapping from DEPTH-1 to 0.
- Read accept = rd_en & ~empty, evaluated before the edge. On an accepted read: dout <= mem[rptr] and rptr increments. Read latency is 1 cycle: data is valid on dout after the edge that accepts the read.
- dout holds its last value when no read is accepted, including when rd_en=1 while empty.
- Flags are registered or derived from pointers, with no combinational path from wr_en or rd_en:
  - empty = (wptr == rptr)
  - full = (wptr[ADDR] != rptr[ADDR]) and (low bits equal)
- Flags and data_count update on the same edge as the accepted operation.
- data_count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted; count unchanged.
  - Empty: write accepted, read rejected (no bypass). empty deasserts next cycle, dout unchanged, underflow sets.
  - Full: read accepted, write rejected. full deasserts, din is discarded, overflow sets.
- Overflow: a write attempted while full leaves memory, pointers and count unchanged and sets overflow=1 until reset.
- Underflow: a read attempted while empty sets underflow=1 until reset.
- Ordering: strict first-in, first-out across any number of pointer wraps.

Test Plan:
- Reset: drive rst=1 with no clock edge -> empty=1, full=0, dout=0, data_count=0, overflow=0, underflow=0 immediately.
- Fill: write 1000,1001,... on consecutive cycles -> full=1 after the 64th accepted write (value 1063), data_count=64. Further writes while full are ignored and overflow=1.
- Drain: rd_en=1 until empty -> dout sequence is 1000..1063, one value per cycle, each appearing one cycle after its read edge. empty=1 after the 64th read. An extra read leaves dout=1063 and sets underflow=1.
- Concurrent: write 2000..2029 (30 cycles); start rd_en 5 cycles into the writes and hold it for 20 cycles -> reads return 2000..2019 in order, data_count stays constant during overlap and reaches 10 at the end. Three more reads return 2020..2022.
- Wrap and full-protect: write 3000.. after the pointers have wrapped -> full after 64 accepted words. Drive din=24'h000FFF with wr_en=1 while full, then drain -> 24'h000FFF never appears on dout, and data order is preserved.
- Reset mid-operation: with 10 words stored, pulse rst -> empty=1 and data_count=0 immediately. Write 0xABCDEF, then read -> dout=0xABCDEF.
